// File: rtl/coproc_pkg.sv
// coproc_pkg: opcodes, instruction field positions and decoder FSM encoding shared by the coprocessor.
package coproc_pkg;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_SUM   = 4'b0011;
    localparam int OP_LSB   = 0;
    localparam int COL_LSB  = 4;
    localparam int ROW_LSB  = 7;
    localparam int SEL_LSB  = 10;
    localparam int DATA_LSB = 12;
    localparam int FLAG_LSB = 20;
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_WRITE, S_READ, S_EXEC, S_WAIT, S_FIN
    } state_t;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered rising-edge pulse; history resets high so a level held through reset is not an edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic prev;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prev <= 1'b1;
            rise <= 1'b0;
        end else begin
            prev <= d;
            rise <= d & ~prev;
        end
endmodule

// File: rtl/instr_decoder.sv
// instr_decoder: button-launched instruction sequencer driving matrix memory and ALU.
// Define INSTR_DECODER_ERR_EN to make illegal opcodes raise a sticky err.
module instr_decoder
    import coproc_pkg::*;
#(
    parameter int INSTR_W = 22,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               start,
    output logic               mem_we,
    output logic [1:0]         mem_sel,
    output logic [IDX_W-1:0]   mem_row,
    output logic [IDX_W-1:0]   mem_col,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               alu_start,
    output logic [3:0]         alu_op,
    output logic [1:0]         alu_flags,
    input  logic               alu_done,
    output logic [DATA_W-1:0]  result,
    output logic               busy,
    output logic               done,
    output logic               err
);
    state_t state;
    logic [INSTR_W-1:0] ir;
    logic rise, rd_ph;
`ifdef INSTR_DECODER_ERR_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    edge_detect u_edge (.clk(clk), .rst(rst), .d(start), .rise(rise));

    // Address, data and opcode come straight from the latched word, so they hold until the next accept.
    assign mem_sel   = ir[SEL_LSB +: 2];
    assign mem_row   = ir[ROW_LSB +: IDX_W];
    assign mem_col   = ir[COL_LSB +: IDX_W];
    assign mem_wdata = ir[DATA_LSB +: DATA_W];
    assign alu_op    = ir[OP_LSB +: 4];
    assign alu_flags = ir[FLAG_LSB +: 2];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= S_IDLE;
            ir        <= '0;
            rd_ph     <= 1'b0;
            mem_we    <= 1'b0;
            alu_start <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
`ifdef INSTR_DECODER_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            mem_we    <= 1'b0;
            alu_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: if (rise) begin
                    ir    <= instr_in;
                    state <= S_DECODE;
                    busy  <= 1'b1;
`ifdef INSTR_DECODER_ERR_EN
                    err_q <= 1'b0;
`endif
                end
                S_DECODE: begin
                    rd_ph <= 1'b0;
                    case (ir[OP_LSB +: 4])
                        OP_STORE: begin state <= S_WRITE; mem_we <= 1'b1; end
                        OP_LOAD:  state <= S_READ;
                        OP_SUM:   begin state <= S_EXEC; alu_start <= 1'b1; end
                        default: begin
                            state <= S_FIN;
                            done  <= 1'b1;
`ifdef INSTR_DECODER_ERR_EN
                            err_q <= 1'b1;
`endif
                        end
                    endcase
                end
                S_WRITE: begin state <= S_FIN; done <= 1'b1; end
                // First READ cycle lets the memory see the address; the second captures its data.
                S_READ: begin
                    rd_ph <= 1'b1;
                    if (rd_ph) begin
                        result <= mem_rdata;
                        state  <= S_FIN;
                        done   <= 1'b1;
                    end
                end
                S_EXEC: state <= S_WAIT;
                S_WAIT: if (alu_done) begin state <= S_FIN; done <= 1'b1; end
                S_FIN: begin state <= S_IDLE; busy <= 1'b0; end
                default: begin state <= S_IDLE; busy <= 1'b0; end
            endcase
        end
endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 Parameter INSTR_W, default 22, instruction word width.
REQ-002 Parameter DATA_W, default 8, element data width.
REQ-003 Parameter IDX_W, default 3, row/column index width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 instr_in  in  INSTR_W  instruction word: [3:0] opcode, [6:4] col, [9:7] row, [11:10] matrix sel, [19:12] data, [21:20] flags.
REQ-007 start  in  1  level strobe from a debounced button; its rising edge requests execution of instr_in.
REQ-008 mem_we  out  1  one-cycle matrix-memory write enable.
REQ-009 mem_sel/mem_row/mem_col  out  2/IDX_W/IDX_W  memory address.
REQ-010 mem_wdata  out  DATA_W  write data; mem_rdata  in  DATA_W  read data, valid one cycle after address.
REQ-011 alu_start  out  1  one-cycle ALU launch; alu_op  out  4  opcode held while busy; alu_done  in  1  ALU completion pulse.
REQ-012 result  out  DATA_W  last LOAD value; busy, done, err  out  1  status.

Function
REQ-013 The block SHALL sample instr_in into an internal register on the cycle a start rising edge is detected in IDLE.
REQ-014 FSM states SHALL be IDLE, DECODE, WRITE, READ, EXEC, WAIT, FIN.
REQ-015 IDLE->DECODE on start edge; start edges outside IDLE SHALL be ignored, not queued.
REQ-016 DECODE SHALL branch: opcode 4'b0010 STORE->WRITE, 4'b0001 LOAD->READ, 4'b0011 SUM->EXEC, any other->FIN with illegal flag set.
REQ-017 WRITE SHALL assert mem_we for exactly one cycle with latched sel/row/col/data, then go to FIN.
REQ-018 READ SHALL drive the address, capture mem_rdata into result on the following cycle, then go to FIN (2-cycle READ).
REQ-019 EXEC SHALL pulse alu_start one cycle and go to WAIT; WAIT SHALL hold until alu_done, then go to FIN.
REQ-020 alu_done arriving in the same cycle as alu_start SHALL be ignored; only alu_done seen in WAIT counts.
REQ-021 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 Start-edge-to-mem_we latency SHALL be 3 cycles (edge detect, DECODE, WRITE); edge-to-done for STORE 4 cycles.
REQ-024 mem_sel/row/col/wdata/alu_op SHALL remain stable from DECODE until IDLE is re-entered.
REQ-025 Flags [21:20] SHALL be passed through unchanged on alu_op's companion field only; no other interpretation.

Reset
REQ-026 On rst the FSM SHALL enter IDLE and mem_we, alu_start, done, busy, err, result, address/data outputs SHALL be 0, asynchronously.
REQ-027 The edge detector history SHALL reset to 1 so a start held high through reset release does not trigger.
REQ-028 Reset mid-operation (including WAIT) SHALL abandon the instruction with no write or done pulse afterward.

Configuration
REQ-029 Macro INSTR_DECODER_ERR_EN: defined -> illegal opcode sets err sticky until the next accepted start edge; undefined -> err tied 0 and illegal opcodes complete silently via FIN with done.

Structure
REQ-030 Opcode constants, field bit positions and FSM state encoding SHALL reside in the shared package coproc_pkg.
REQ-031 Start rising-edge detection SHALL be a sub-module named edge_detect (1-bit, registered, resettable).

Verification
REQ-032 STORE: instr 22'b10_11111111_00_000_000_0010, start edge -> mem_we 1 cycle at cycle 3, sel 0, row 0, col 0, wdata 8'hFF; done at cycle 4.
REQ-033 SUM: opcode 0011, alu_done returned 5 cycles after alu_start -> busy held through WAIT, done one cycle after alu_done, no mem_we.
REQ-034 LOAD: sel 1,row 2,col 3, mem_rdata 8'h5A -> result 8'h5A, done pulse, busy low next cycle.
REQ-035 Illegal opcode 4'b1111 with INSTR_DECODER_ERR_EN -> err 1 and stays; next STORE start clears err; without macro err stays 0.
REQ-036 Second start edge during WAIT -> ignored; rst asserted in WAIT -> all outputs 0 immediately, later alu_done produces no done.
